// File: rtl/fir_mem_pkg.sv
// Shared widths, sequencer state encoding and a small index helper for the
// memory-to-FIFO streaming path.
package fir_mem_pkg;

    localparam int AWIDTH = 12;
    localparam int DWIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Folds an index that may have run at most one lap past the end of a ring.
    function automatic int wrap_idx(input int idx, input int depth);
        return (idx >= depth) ? idx - depth : idx;
    endfunction

endpackage

// File: rtl/mem_skid_buf.sv
// Small ring buffer that holds memory read data the FIFO could not take yet.
// Push and pop may happen in the same cycle, including when the ring is full.
module mem_skid_buf #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);
    import fir_mem_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr   = PW'(wrap_idx(int'(rd_ptr_q) + int'(count_q), DEPTH));
        rd_ptr_d = rd_ptr_q;
        if (pop_i) begin
            rd_ptr_d = PW'(wrap_idx(int'(rd_ptr_q) + 1, DEPTH));
        end
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr] <= din_i;
        end
    end

    // The read credit in the sequencer must make both of these impossible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push_i && !pop_i && count_q == CW'(DEPTH)));
            assert (!(pop_i && count_q == '0));
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mem_fifo_loader.sv
// Streams a block of memory words into the FIR sample FIFO while sharing the
// single memory port with a host write port that always wins arbitration.
module mem_fifo_loader #(
    parameter int AWIDTH     = fir_mem_pkg::AWIDTH,
    parameter int DWIDTH     = fir_mem_pkg::DWIDTH,
    parameter int SKID_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    output logic              busy,
    output logic              done,
    input  logic              host_wr_req,
    input  logic [AWIDTH-1:0] host_wr_addr,
    input  logic [DWIDTH-1:0] host_wr_data,
    output logic              host_wr_ack,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data_in,
    output logic              mem_wen_n,
    input  logic [DWIDTH-1:0] mem_data_out,
    output logic [DWIDTH-1:0] fifo_datain,
    output logic              fifo_write,
    input  logic              fifo_full
);
    import fir_mem_pkg::*;

    localparam int CW = $clog2(SKID_DEPTH + 1);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [AWIDTH:0]   reads_left_q, reads_left_d;
    logic [AWIDTH:0]   pushes_left_q, pushes_left_d;
    logic              inflight_q;
    logic              fifo_write_q;
    logic [DWIDTH-1:0] fifo_data_q, fifo_data_d;

    logic [CW-1:0]     skid_count;
    logic [DWIDTH-1:0] skid_head;
    logic              active, pop, bypass, skid_push, skid_pop, rd_issue;
    logic [CW:0]       level_next;

    // When the skid is empty, returning read data goes straight to the FIFO
    // register; this is what keeps read-to-write latency at two cycles.
    always_comb begin
        active      = (state_q == RUN) || (state_q == DRAIN);
        pop         = active && (skid_count != '0 || inflight_q) && !fifo_full;
        bypass      = pop && (skid_count == '0);
        skid_push   = inflight_q && !bypass;
        skid_pop    = pop && (skid_count != '0);
        fifo_data_d = fifo_data_q;
        if (pop) begin
            fifo_data_d = bypass ? mem_data_out : skid_head;
        end
        level_next = {1'b0, skid_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        rd_issue   = (state_q == RUN) && !host_wr_req && (reads_left_q != '0)
                     && (level_next < (CW+1)'(SKID_DEPTH));
    end

    always_comb begin
        host_wr_ack = host_wr_req;
        mem_wen_n   = 1'b1;
        mem_addr    = '0;
        mem_data_in = '0;
        if (host_wr_req) begin
            mem_wen_n   = 1'b0;
            mem_addr    = host_wr_addr;
            mem_data_in = host_wr_data;
        end else if (rd_issue) begin
            mem_addr = rd_addr_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        reads_left_d  = reads_left_q;
        pushes_left_d = pushes_left_q;
        if (rd_issue) begin
            rd_addr_d    = rd_addr_q + AWIDTH'(1);
            reads_left_d = reads_left_q - (AWIDTH+1)'(1);
        end
        if (pop) begin
            pushes_left_d = pushes_left_q - (AWIDTH+1)'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d     = base_addr;
                    reads_left_d  = length;
                    pushes_left_d = length;
                    state_d       = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_issue && reads_left_q == (AWIDTH+1)'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && pushes_left_q == (AWIDTH+1)'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rd_addr_q     <= '0;
            reads_left_q  <= '0;
            pushes_left_q <= '0;
            inflight_q    <= 1'b0;
            fifo_write_q  <= 1'b0;
            fifo_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            reads_left_q  <= reads_left_d;
            pushes_left_q <= pushes_left_d;
            inflight_q    <= rd_issue;
            fifo_write_q  <= pop;
            fifo_data_q   <= fifo_data_d;
        end
    end

    mem_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (DWIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .din_i   (mem_data_out),
        .head_o  (skid_head),
        .count_o (skid_count)
    );

    assign busy        = active;
    assign done        = (state_q == DONE);
    assign fifo_write  = fifo_write_q;
    assign fifo_datain = fifo_data_q;

endmodule
